spi_slave_fsm: RTL and testbench

SPI slave front end of the SPI-to-RAM path. Deserialises MOSI frames while ss_n is low and presents each completed 10-bit frame to the single-port RAM controller as rx_data with a one-cycle rx_valid. When the controller returns read data with tx_valid, the block serialises those 8 bits onto MISO.

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_slave_fsm_tx_shifter.sv | 50 +++++
 rtl/spi_slave_fsm.sv | 112 +++++++++++
 tb/tb_spi_slave_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end: FSM states, command codes
// and default widths.
package spi_pkg;

  localparam int FRAME_W_DEF = 10;
  localparam int DATA_W_DEF  = 8;
  localparam int CNT_W       = 4;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  function automatic logic is_data_state(state_t s);
    return s inside {WRITE, READ_ADD, READ_DATA};
  endfunction

  // The second command bit is not yet known in CHK_CMD, so the read path is chosen
  // from whether a read address has already been received.
  function automatic state_t path_for_cmd(logic [1:0] cmd);
    state_t s;
    case (cmd)
      CMD_WR_ADDR, CMD_WR_DATA: s = WRITE;
      CMD_RD_ADDR:              s = READ_ADD;
      CMD_RD_DATA:              s = READ_DATA;
      default:                  s = WRITE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/spi_slave_fsm_tx_shifter.sv
// MISO serialiser: captures read data on load, shifts it out MSB first over DATA_W
// cycles, then holds miso low and raises done until cleared.
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] sh_q;
  logic [CW-1:0]     cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      miso  <= 1'b0;
      sh_q  <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      miso  <= data[DATA_W-1];
      sh_q  <= {data[DATA_W-2:0], 1'b0};
      cnt_q <= CW'(DATA_W - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (cnt_q != '0) begin
        miso  <= sh_q[DATA_W-1];
        sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
        cnt_q <= cnt_q - 1'b1;
      end else begin
        miso <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises 10-bit frames to the RAM controller and returns
// read data on MISO. Optional macro SPI_FRAME_ERR_EN adds the frame_err abort pulse.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic               frame_err
`endif
);

  state_t             state_q, state_d;
  logic [FRAME_W-2:0] shift_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               frame_done_q;
  logic               rd_addr_seen_q;

  logic data_state, last_bit, shift_en;
  logic tx_wait, tx_load, tx_clear, tx_busy, tx_done;

  assign data_state = is_data_state(state_q);
  // The final bit completes the frame even if ss_n rises in the same cycle.
  assign last_bit   = data_state && !frame_done_q && (bit_cnt_q == CNT_W'(FRAME_W - 1));
  assign shift_en   = (state_q == CHK_CMD && !ss_n)
                   || (data_state && !frame_done_q && (!ss_n || last_bit));

  assign tx_wait  = (state_q == READ_DATA) && frame_done_q && !tx_busy && !tx_done;
  assign tx_load  = tx_wait && tx_valid && !ss_n;
  assign tx_clear = (state_q == IDLE) || ss_n;

  // NOTE: next state gets its default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!ss_n) state_d = CHK_CMD;
      CHK_CMD: state_d = ss_n ? IDLE : path_for_cmd({mosi, rd_addr_seen_q});
      default: if (ss_n) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      frame_done_q   <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_valid <= last_bit;
      if (state_q == IDLE) begin
        shift_q      <= '0;
        bit_cnt_q    <= '0;
        frame_done_q <= 1'b0;
      end else if (shift_en) begin
        shift_q   <= {shift_q[FRAME_W-3:0], mosi};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (last_bit) begin
        frame_done_q <= 1'b1;
        rx_data      <= {shift_q, mosi};
        if (state_q == READ_ADD)  rd_addr_seen_q <= 1'b1;
        if (state_q == READ_DATA) rd_addr_seen_q <= 1'b0;
      end
    end
  end

  spi_tx_shifter #(
    .DATA_W(DATA_W)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(tx_clear),
    .load (tx_load),
    .data (tx_data),
    .miso (miso),
    .busy (tx_busy),
    .done (tx_done)
  );

`ifdef SPI_FRAME_ERR_EN
  // An abort counts as an error until the frame is complete and, on the read-data
  // path, until the MISO transfer has finished.
  logic err_cond;
  assign err_cond = ss_n && ((state_q == CHK_CMD)
                          || (data_state && !frame_done_q && !last_bit)
                          || (state_q == READ_DATA && frame_done_q && !tx_done));

  always_ff @(posedge clk) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= err_cond;
  end
`else
  // Aborts are silent in this build.
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Scoreboard bench for spi_slave_fsm: expected frames, MISO bits and abort pulses are
// queued with their due cycle when driven and compared every falling edge.
module tb_spi_slave_fsm;
  import spi_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n, ss_n, mosi, tx_valid;
  logic                   miso, rx_valid;
  logic [FRAME_W_DEF-1:0] rx_data;
  logic [DATA_W_DEF-1:0]  tx_data;
`ifdef SPI_FRAME_ERR_EN
  logic                   frame_err;
`endif

  spi_slave_fsm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .miso    (miso),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [9:0] data; int cyc; } rx_exp_t;
  typedef struct { logic b; int cyc; } bit_exp_t;

  rx_exp_t  rx_q[$];
  bit_exp_t miso_q[$];
  int       err_q[$];
  int       checks = 0;
  int       errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rx_q.size() != 0 && rx_q[0].cyc == cyc) begin
      check("rx_valid", 32'(rx_valid), 32'd1);
      check("rx_data", 32'(rx_data), 32'(rx_q[0].data));
      rx_q.delete(0);
    end else begin
      check("rx_valid_idle", 32'(rx_valid), 32'd0);
    end
    if (miso_q.size() != 0 && miso_q[0].cyc == cyc) begin
      check("miso_bit", 32'(miso), 32'(miso_q[0].b));
      miso_q.delete(0);
    end else begin
      check("miso_idle", 32'(miso), 32'd0);
    end
`ifdef SPI_FRAME_ERR_EN
    if (err_q.size() != 0 && err_q[0] == cyc) begin
      check("frame_err", 32'(frame_err), 32'd1);
      err_q.delete(0);
    end else begin
      check("frame_err_idle", 32'(frame_err), 32'd0);
    end
`endif
  end

  task automatic slot();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      slot();
      mosi = 1'($urandom);
    end
  endtask

  task automatic trim_miso();
    while (miso_q.size() != 0 && miso_q[$].cyc > cyc) miso_q.delete(miso_q.size() - 1);
  endtask

  task automatic start_frame();
    slot();
    ss_n = 1'b0;
    mosi = 1'($urandom);
  endtask

  task automatic send_bits(input logic [9:0] f, input int n, input bit raise_last);
    for (int i = 0; i < n; i++) begin
      slot();
      mosi = f[9-i];
      if (i == 9) rx_q.push_back('{f, cyc + 1});
      if (raise_last && i == n - 1) ss_n = 1'b1;
    end
  endtask

  task automatic frame(input logic [9:0] f);
    start_frame();
    send_bits(f, 10, 1'b0);
  endtask

  task automatic end_frame(input bit exp_err);
    slot();
    ss_n = 1'b1;
    mosi = 1'($urandom);
    if (exp_err) err_q.push_back(cyc + 1);
    trim_miso();
  endtask

  task automatic send_tx(input logic [7:0] d, input bit accept);
    slot();
    tx_valid = 1'b1;
    tx_data  = d;
    if (accept)
      for (int i = 0; i < 8; i++) miso_q.push_back('{d[7-i], cyc + 1 + i});
    slot();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  initial begin
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) slot();
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;

    // Write address, extra MOSI bits after completion ignored
    frame(10'h0A5); idle(3); end_frame(1'b0);

    // Write data with tx_valid held high (outside the read window)
    tx_valid = 1'b1; tx_data = 8'hFF;
    frame(10'h13C); idle(1);
    tx_valid = 1'b0;
    end_frame(1'b0);

    // Read address, then a stray tx_valid
    frame(10'h207); idle(1); send_tx(8'h5A, 1'b0); end_frame(1'b0);

    // Read data, MISO returns 0xC3
    frame(10'h35A); idle(1); send_tx(8'hC3, 1'b1); idle(10); end_frame(1'b0);

    // rd_addr_seen cleared: next read-type frame takes the address path
    frame(10'h3FF); idle(1); send_tx(8'h55, 1'b0); end_frame(1'b0);

    // Read data, aborted mid-MISO shift
    frame(10'h2AA); idle(1); send_tx(8'h96, 1'b1); idle(2); end_frame(1'b1);

    // Abort after 5 bits, abort in CHK_CMD, abort while awaiting tx_valid
    start_frame(); send_bits(10'h0A5, 5, 1'b0); end_frame(1'b1);
    start_frame(); end_frame(1'b1);
    frame(10'h201); end_frame(1'b0);
    frame(10'h3C0); idle(2); end_frame(1'b1);

    // Full frame decodes after the aborts
    frame(10'h0F0); end_frame(1'b0);

    // ss_n rises together with the 10th bit
    start_frame(); send_bits(10'h155, 10, 1'b1); idle(1);

    // Reset in the middle of a MISO transfer
    frame(10'h211); end_frame(1'b0);
    frame(10'h3EE); idle(1); send_tx(8'hFF, 1'b1); idle(1);
    slot();
    rst_n = 1'b0;
    ss_n  = 1'b1;
    trim_miso();
    slot();
    check("rst2_miso", 32'(miso), 32'd0);
    check("rst2_rx_valid", 32'(rx_valid), 32'd0);
    check("rst2_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;

    // After reset a 1-led frame is a read address, then read data works
    frame(10'h3C3); idle(1); send_tx(8'hA5, 1'b0); end_frame(1'b0);
    frame(10'h300); idle(1); send_tx(8'h81, 1'b1); idle(9); end_frame(1'b0);
    idle(3);

    check("rx_q_left", 32'(rx_q.size()), 32'd0);
    check("miso_q_left", 32'(miso_q.size()), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    check("err_q_left", 32'(err_q.size()), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
